// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//
// Multi-port register file for the RISC-V datapath. It is also used as a
// scratch bank by the HW accelerator.
//   - NRD registered read ports with one cycle of latency.
//   - Two write ports. Port 1 wins when both ports write the same address,
//     and that case raises a one-cycle wr_collision pulse.
//   - Optional hardwired-zero entry 0 (ZERO_REG).
//   - Optional write-first bypass (BYPASS).
//   - A clear sequencer zeroes every entry after reset. init_busy is high
//     until the clear finishes.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   init_busy     high while the clear sequencer runs
//   ren           per-port read enable              [NRD]
//   raddr         packed read addresses             [NRD*AWIDTH]
//   rdata         packed registered read data       [NRD*DWIDTH]
//   we0/waddr0/wdata0   write port 0
//   we1/waddr1/wdata1   write port 1
//   wr_collision  registered pulse: both ports wrote the same address
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int DWIDTH   = 64,
    parameter int AWIDTH   = 5,
    parameter int DEPTH    = 2**AWIDTH,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_busy,
    input  logic [NRD-1:0]           ren,
    input  logic [NRD*AWIDTH-1:0]    raddr,
    output logic [NRD*DWIDTH-1:0]    rdata,
    input  logic                     we0,
    input  logic [AWIDTH-1:0]        waddr0,
    input  logic [DWIDTH-1:0]        wdata0,
    input  logic                     we1,
    input  logic [AWIDTH-1:0]        waddr1,
    input  logic [DWIDTH-1:0]        wdata1,
    output logic                     wr_collision
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

    state_t              state;
    state_t              next_state;
    logic [AWIDTH-1:0]   cnt;
    logic [DWIDTH-1:0]   mem [DEPTH];
    logic                wen0;
    logic                wen1;

    // State register. Reset always restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Leave CLEAR on the same edge that zeroes the last entry.
    always_comb begin
        next_state = state;
        if (state == CLEAR && cnt == LAST) begin
            next_state = READY;
        end
    end

    // Clear pointer. It wraps to 0 on the final clear edge, and nothing
    // reads it in READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + AWIDTH'(1);
        end
    end

    assign init_busy = (state == CLEAR);

    // User writes count only in READY. With ZERO_REG, writes to address 0
    // are dropped here, so they are neither stored nor bypassed.
    assign wen0 = (state == READY) && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wen1 = (state == READY) && we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    // Storage array. Port 1 is written last, so it wins on a same-address
    // dual write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else begin
                if (wen0) begin
                    mem[waddr0] <= wdata0;
                end
                if (wen1) begin
                    mem[waddr1] <= wdata1;
                end
            end
        end
    end

    // The collision flag uses the raw enables. A dual write to the
    // hardwired-zero entry therefore still reports a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= (state == READY) && we0 && we1 && (waddr0 == waddr1);
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AWIDTH-1:0] addr;
        logic              is_zero;
        logic              hit0;
        logic              hit1;
        logic [DWIDTH-1:0] rd_next;
        logic [DWIDTH-1:0] rd_q;

        assign addr    = raddr[i*AWIDTH +: AWIDTH];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit0    = (BYPASS != 0) && wen0 && (waddr0 == addr);
        assign hit1    = (BYPASS != 0) && wen1 && (waddr1 == addr);

        // Priority from lowest to highest: stored data, port 0 bypass,
        // port 1 bypass, forced zero. The forced zero also masks entries
        // that are not yet cleared during CLEAR.
        always_comb begin
            rd_next = mem[addr];
            if (hit0) begin
                rd_next = wdata0;
            end
            if (hit1) begin
                rd_next = wdata1;
            end
            if (is_zero || state == CLEAR) begin
                rd_next = '0;
            end
        end

        // Output register. It holds its value while ren is low.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (ren[i]) begin
                rd_q <= rd_next;
            end
        end

        assign rdata[i*DWIDTH +: DWIDTH] = rd_q;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor register file for the RISC-V datapath: one clock, NRD synchronous read ports, two write ports, optional hardwired-zero entry 0, and optional write-first bypass.
- A hardware clear sequencer zeroes every entry after reset, so no load file is needed.
- Sits between decode (reads) and writeback (writes); the HW accelerator also uses it as a scratch bank.

Parameters:
- DWIDTH, 64, data width in bits.
- AWIDTH, 5, address width.
- DEPTH, 2**AWIDTH, number of entries.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, if 1 entry 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, if 1 a read of an address written in the same cycle returns the new data (write-first); if 0 it returns the old data (read-first).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the clear sequencer runs.
- ren  in  NRD  per-port read enable.
- raddr  in  NRD*AWIDTH  packed read addresses; port i at [i*AWIDTH +: AWIDTH].
- rdata  out  NRD*DWIDTH  packed registered read data; port i at [i*DWIDTH +: DWIDTH].
- we0  in  1  write enable, port 0.
- waddr0  in  AWIDTH  write address, port 0.
- wdata0  in  DWIDTH  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  AWIDTH  write address, port 1.
- wdata1  in  DWIDTH  write data, port 1.
- wr_collision  out  1  one-cycle pulse: both ports wrote the same address.

Behaviour:
- Reset: while rst=1 → rdata=0, wr_collision=0, init_busy=1, clear counter=0, state=CLEAR. The clock and reset ports are one clock and a synchronous, active-high reset; polarity and synchronicity are fixed.
- FSM states: CLEAR and READY.
- CLEAR: each cycle writes 0 to entry[cnt] and increments cnt. When cnt==DEPTH-1, that entry is written and the FSM moves to READY the next cycle. Total clear time is DEPTH cycles after rst deasserts.
- In CLEAR: user writes (we0/we1) are ignored; reads with ren=1 return 0; wr_collision stays 0.
- READY: init_busy=0. Stays in READY until rst.
- rst asserted mid-CLEAR or in READY → cnt restarts at 0 and the FSM returns to CLEAR; no partial state survives.
- Read latency is 1 cycle. With ren[i]=1 at edge k, rdata port i holds the value at edge k. With ren[i]=0, rdata port i holds its previous value.
- Write: we=1 at edge k → entry updated at edge k and visible to a read issued at k+1.
- Same-cycle read/write to the same address, per read port:
  - BYPASS=1 → returns the write data, with port 1 data if both ports hit.
  - BYPASS=0 → returns the pre-write contents.
- Dual write to the same address (we0=we1=1, waddr0==waddr1) → port 1 data is stored and wr_collision=1 for one cycle (registered, visible after the edge).
- ZERO_REG=1:
  - A write to address 0 is dropped and is not bypassed.
  - A read of address 0 returns 0.
  - A dual write to address 0 still pulses wr_collision.
- Reads on distinct ports are independent; the same address on several ports is legal.
- No X on any output after reset; the array is never read uninitialised once READY.

Test Plan:
- Clear: assert rst 2 cycles, deassert → init_busy high for exactly 32 cycles (DEPTH=32), then 0. Reading all 32 addresses returns 0x0. A write of 0xDEAD to addr 5 during CLEAR is lost (addr 5 reads 0).
- Basic R/W: we0 addr 3 = 0x1122334455667788; next cycle ren=2'b11, raddr={3,3} → both ports show 0x1122334455667788 one cycle later. With ren=0, rdata holds.
- Bypass: BYPASS=1, we1 addr 7 = 0xA5 and read addr 7 in the same cycle → rdata=0xA5. Repeat with BYPASS=0 over an old value of 0x11 → rdata=0x11, and the next read gives 0xA5.
- Collision: we0 addr 9 = 0x1, we1 addr 9 = 0x2 → wr_collision pulses 1 cycle and a read of addr 9 returns 0x2. A dual write to addr 0 with ZERO_REG=1 pulses the flag and addr 0 still reads 0.
- Zero register: we0 addr 0 = 0xFFFF → a read of addr 0 returns 0, including the same-cycle bypass case.
- Reset mid-operation: fill addrs 1..4, then assert rst at clear cycle 10 of a second reset sequence → the FSM restarts, init_busy lasts a full 32 cycles after release, and addrs 1..4 read 0.
